// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imm_gen_pipe                                                 |
// | Description : RV32/RV64 immediate generator followed by a 2-entry skid     |
// |               buffer carrying {imm, tag, illegal} with valid/ready.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [24:0]      in_din,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  generate
    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
      $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (TAG_W < 1) begin : g_bad_tag_w
      $fatal(1, "imm_gen_pipe: TAG_W must be at least 1");
    end
  endgenerate

  localparam logic [3:0] c_OP_I    = 4'd0;
  localparam logic [3:0] c_OP_IS   = 4'd1;
  localparam logic [3:0] c_OP_S    = 4'd2;
  localparam logic [3:0] c_OP_U    = 4'd3;
  localparam logic [3:0] c_OP_B    = 4'd4;
  localparam logic [3:0] c_OP_J    = 4'd5;
  localparam logic [3:0] c_OP_Z    = 4'd6;
  localparam logic [3:0] c_OP_NONE = 4'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q;
  entry_t          head_q;
  entry_t          tail_q;
  entry_t          w_new;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  logic            w_push;
  logic            w_pop;

  // Size casts of signed operands sign-extend straight to XLEN.
  always_comb begin
    w_imm     = '0;
    w_illegal = 1'b0;
    case (in_op)
      c_OP_I:    w_imm = XLEN'($signed(in_din[24:13]));
      c_OP_IS:   w_imm = (XLEN == 64) ? XLEN'(in_din[18:13]) : XLEN'(in_din[17:13]);
      c_OP_S:    w_imm = XLEN'($signed({in_din[24:18], in_din[4:0]}));
      c_OP_U:    w_imm = XLEN'($signed({in_din[24:5], 12'b0}));
      c_OP_B:    w_imm = XLEN'($signed({in_din[24], in_din[0], in_din[23:18],
                                        in_din[4:1], 1'b0}));
      c_OP_J:    w_imm = XLEN'($signed({in_din[24], in_din[12:5], in_din[13],
                                        in_din[23:14], 1'b0}));
      c_OP_Z:    w_imm = XLEN'(in_din[12:8]);
      c_OP_NONE: w_imm = '0;
      default:   w_illegal = 1'b1;
    endcase
  end

  assign w_new.imm     = w_imm;
  assign w_new.tag     = in_tag;
  assign w_new.illegal = w_illegal;

  // Ready depends only on registered state, never on out_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign out_imm     = head_q.imm;
  assign out_tag     = head_q.tag;
  assign out_illegal = head_q.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (w_push) begin
            head_q  <= w_new;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            head_q <= w_new;
          end else if (w_push) begin
            tail_q  <= w_new;
            state_q <= FULL;
          end else if (w_pop) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            head_q  <= tail_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_imm_gen_pipe                                              |
// | Description : Bench for imm_gen_pipe, XLEN=32 and XLEN=64 side by side.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_op = 4'd0;
  logic [24:0] in_din = '0;
  logic [7:0]  in_tag = '0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [7:0]  out_tag32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [7:0]  out_tag64;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] i32;
    logic [63:0] i64;
    logic [7:0]  tag;
    logic        ill;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_op(in_op),
    .in_din(in_din), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_illegal(out_illegal32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_op(in_op),
    .in_din(in_din), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  // Two's-complement sign extension of an n-bit field by arithmetic.
  function automatic logic [63:0] sx(input logic [63:0] v, input int n);
    return v[n-1] ? v - (64'd1 << n) : v;
  endfunction

  function automatic logic [63:0] exp_imm(input logic [3:0] op, input logic [24:0] d, input int xl);
    logic [63:0] x, r;
    x = {39'd0, d};
    case (op)
      4'd0: r = sx(x >> 13, 12);
      4'd1: r = (x >> 13) & ((xl == 32) ? 64'd31 : 64'd63);
      4'd2: r = sx(((x >> 18) << 5) | (x & 64'd31), 12);
      4'd3: r = sx((x >> 5) << 12, 32);
      4'd4: r = sx(((x >> 24) << 12) | ((x & 64'd1) << 11) |
                   (((x >> 18) & 64'd63) << 5) | (((x >> 1) & 64'd15) << 1), 13);
      4'd5: r = sx(((x >> 24) << 20) | (((x >> 5) & 64'd255) << 12) |
                   (((x >> 13) & 64'd1) << 11) | (((x >> 14) & 64'd1023) << 1), 21);
      4'd6: r = (x >> 8) & 64'd31;
      default: r = 64'd0;
    endcase
    if (xl == 32) r = r & 64'hFFFF_FFFF;
    return r;
  endfunction

  // Drive one cycle and advance the FIFO model; checks live in the test tasks.
  task automatic step(input logic v, input logic [3:0] op, input logic [24:0] din,
                      input logic [7:0] tag, input logic rdy, input logic fl);
    ent_t        e;
    logic [63:0] t;
    bit          do_push, do_pop;
    in_valid  = v;
    in_op     = op;
    in_din    = din;
    in_tag    = tag;
    out_ready = rdy;
    flush     = fl;
    do_push = v && (q.size() < 2);
    do_pop  = rdy && (q.size() > 0);
    t      = exp_imm(op, din, 32);
    e.i32  = t[31:0];
    e.i64  = exp_imm(op, din, 64);
    e.tag  = tag;
    e.ill  = (op > 4'd7);
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_handshake: got v32=%b v64=%b r32=%b r64=%b, want v=0 r=1",
               out_valid32, out_valid64, in_ready32, in_ready64);
    end
    n_checks++;
    if (out_imm32 !== 32'd0 || out_imm64 !== 64'd0 || out_tag32 !== 8'd0 || out_illegal64 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_payload: got imm32=%h imm64=%h tag=%h ill=%b, want all 0",
               out_imm32, out_imm64, out_tag32, out_illegal64);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [3:0]  ops[6]  = '{4'd0, 4'd4, 4'd3, 4'd6, 4'd3, 4'd1};
    logic [24:0] dins[6] = '{25'h1FFE001, 25'h1FC001D, 25'h02468A1,
                             25'h0001F00, 25'h1000001, 25'h007E000};
    logic [31:0] e32[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000,
                             32'h0000001F, 32'h80000000, 32'h0000001F};
    logic [63:0] e64[6]  = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC,
                             64'h00000000_12345000, 64'h00000000_0000001F,
                             64'hFFFFFFFF_80000000, 64'h00000000_0000003F};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, ops[i], dins[i], 8'(8'h40 + i), 1'b1, 1'b0);
      n_checks++;
      if (out_valid32 !== 1'b1 || out_imm32 !== e32[i] || out_illegal32 !== 1'b0 || out_tag32 !== 8'(8'h40 + i)) begin
        n_fail++;
        $display("FAIL vec32[%0d]: got v=%b imm=%h ill=%b tag=%h, want v=1 imm=%h ill=0 tag=%h",
                 i, out_valid32, out_imm32, out_illegal32, out_tag32, e32[i], 8'(8'h40 + i));
      end
      n_checks++;
      if (out_valid64 !== 1'b1 || out_imm64 !== e64[i] || out_illegal64 !== 1'b0) begin
        n_fail++;
        $display("FAIL vec64[%0d]: got v=%b imm=%h ill=%b, want v=1 imm=%h ill=0",
                 i, out_valid64, out_imm64, out_illegal64, e64[i]);
      end
    end
    step(1'b0, 4'd0, 25'd0, 8'd0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
      n_fail++;
      $display("FAIL vec_drain: got v32=%b v64=%b, want 0", out_valid32, out_valid64);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want_tag[5] = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd3};
    logic       want_rdy[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] tags[5]     = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
    logic       ords[5]     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'd0, 25'h0123456, tags[i], ords[i], 1'b0);
      n_checks++;
      if (out_valid32 !== 1'b1 || out_tag32 !== want_tag[i] || in_ready32 !== want_rdy[i] ||
          out_tag64 !== want_tag[i] || in_ready64 !== want_rdy[i]) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got v=%b tag=%h rdy=%b tag64=%h rdy64=%b, want v=1 tag=%h rdy=%b",
                 i, out_valid32, out_tag32, in_ready32, out_tag64, in_ready64, want_tag[i], want_rdy[i]);
      end
    end
    step(1'b0, 4'd0, 25'd0, 8'd0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_drain: got v=%b rdy=%b, want v=0 rdy=1", out_valid32, in_ready32);
    end
  endtask

  task automatic test_illegal();
    step(1'b1, 4'd9, 25'($urandom), 8'hA5, 1'b0, 1'b0);
    n_checks++;
    if (out_valid32 !== 1'b1 || out_imm32 !== 32'd0 || out_illegal32 !== 1'b1 || out_tag32 !== 8'hA5 ||
        out_imm64 !== 64'd0 || out_illegal64 !== 1'b1 || out_tag64 !== 8'hA5) begin
      n_fail++;
      $display("FAIL illegal_op: got v=%b imm32=%h imm64=%h ill=%b/%b tag=%h, want v=1 imm=0 ill=1 tag=a5",
               out_valid32, out_imm32, out_imm64, out_illegal32, out_illegal64, out_tag32);
    end
    step(1'b0, 4'd0, 25'd0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    step(1'b1, 4'd2, 25'h1ABCDEF, 8'h11, 1'b0, 1'b0);
    step(1'b1, 4'd5, 25'h0FEDCBA, 8'h22, 1'b0, 1'b0);
    n_checks++;
    if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1 || out_tag32 !== 8'h11) begin
      n_fail++;
      $display("FAIL flush_fill: got rdy=%b v=%b tag=%h, want rdy=0 v=1 tag=11",
               in_ready32, out_valid32, out_tag32);
    end
    step(1'b1, 4'd0, 25'h0000001, 8'h33, 1'b1, 1'b1);
    n_checks++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_clear: got v=%b rdy=%b v64=%b rdy64=%b, want v=0 rdy=1",
               out_valid32, in_ready32, out_valid64, in_ready64);
    end
    step(1'b0, 4'd0, 25'd0, 8'd0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid32 !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_emit: got v=%b, want 0", out_valid32);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 4'd2, 25'h1555555, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 4'd3, 25'h0AAAAAA, 8'h5B, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || out_imm32 !== 32'd0 || out_imm64 !== 64'd0 ||
        in_ready32 !== 1'b1 || out_tag64 !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b/%b imm32=%h imm64=%h rdy=%b tag=%h, want v=0 imm=0 rdy=1 tag=0",
               out_valid32, out_valid64, out_imm32, out_imm64, in_ready32, out_tag64);
    end
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'd0, 25'h1FFE001, 8'h77, 1'b0, 1'b0);
    n_checks++;
    if (out_valid32 !== 1'b1 || out_tag32 !== 8'h77 || out_imm32 !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL post_reset_accept: got v=%b tag=%h imm=%h, want v=1 tag=77 imm=ffffffff",
               out_valid32, out_tag32, out_imm32);
    end
    step(1'b0, 4'd0, 25'd0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 70), 4'($urandom_range(15)), 25'($urandom), 8'($urandom),
           ($urandom_range(99) < 60), ($urandom_range(99) < 3));
      n_checks++;
      if (out_valid32 !== (q.size() != 0) || out_valid64 !== (q.size() != 0) ||
          in_ready32 !== (q.size() < 2) || in_ready64 !== (q.size() < 2)) begin
        n_fail++;
        $display("FAIL rand_hs[%0d]: got v=%b/%b rdy=%b/%b, want occupancy %0d",
                 i, out_valid32, out_valid64, in_ready32, in_ready64, q.size());
      end
      if (q.size() != 0) begin
        n_checks++;
        if (out_imm32 !== q[0].i32 || out_imm64 !== q[0].i64 || out_tag32 !== q[0].tag ||
            out_tag64 !== q[0].tag || out_illegal32 !== q[0].ill || out_illegal64 !== q[0].ill) begin
          n_fail++;
          $display("FAIL rand_head[%0d]: got imm32=%h imm64=%h tag=%h ill=%b, want imm32=%h imm64=%h tag=%h ill=%b",
                   i, out_imm32, out_imm64, out_tag32, out_illegal32,
                   q[0].i32, q[0].i64, q[0].tag, q[0].ill);
        end
      end
    end
    step(1'b0, 4'd0, 25'd0, 8'd0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 25'd0, 8'd0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator. It takes the upper 25 instruction bits (instr[31:7]) with an immediate-format select and produces an XLEN-wide immediate. It adds RV64 support, a CSR zero-extended format, illegal-op flagging and a sideband tag. A 2-entry skid buffer with valid/ready on both sides sits between decode and execute, so the decode stage can be retimed without a combinational ready path.

Parameters:
XLEN, 32, datapath width; legal values are 32 or 64. Any other value is a fatal elaboration error.
TAG_W, 8, width of the sideband tag carried alongside each immediate (e.g. rd/PC index); minimum 1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all buffered entries
in_valid  input  1  upstream entry valid
in_ready  output  1  buffer can accept an entry
in_op  input  4  format select: 0 I, 1 Is, 2 S, 3 U, 4 B, 5 J, 6 Z, 7 NONE, 8-15 illegal
in_din  input  25  instr[31:7]
in_tag  input  TAG_W  sideband tag
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head
out_imm  output  XLEN  immediate of head entry
out_tag  output  TAG_W  tag of head entry
out_illegal  output  1  head entry had an op code of 8-15

Behaviour:
- Format extraction uses din = instr[31:7]; sgn = din[24]; sign extension is always to the full XLEN.
- I: sext(din[24:13]).
- Is: XLEN=32 gives zext(din[17:13]), with din[18] ignored. XLEN=64 gives zext(din[18:13]).
- S: sext({din[24:18], din[4:0]}).
- U: sext({din[24:5], 12'b0}). The upper 32 bits are copies of din[24] when XLEN=64.
- B: sext({din[24], din[0], din[23:18], din[4:1], 1'b0}).
- J: sext({din[24], din[12:5], din[13], din[23:14], 1'b0}).
- Z: zext(din[12:8]), the CSR uimm.
- NONE: 0, with illegal=0.
- 8-15: imm=0, illegal=1.
- Extraction is computed combinationally on the input side. The registered entry stores {imm, tag, illegal}.
- Buffer occupancy is count in {0,1,2}, with states EMPTY, ONE, FULL.
  - in_ready = (count != 2), decoded from registered count only, with no combinational path from out_ready.
  - out_valid = (count != 0). out_imm, out_tag and out_illegal come from the head slot.
  - push = in_valid & in_ready; pop = out_valid & out_ready.
- State transitions:
  - EMPTY + push: new entry goes to head -> ONE.
  - ONE + push, no pop: new entry goes to tail -> FULL.
  - ONE + push + pop: new entry overwrites head -> stays ONE.
  - ONE + pop: -> EMPTY.
  - FULL + pop: tail moves to head -> ONE. Push is impossible in FULL.
- Latency: an entry pushed at edge N is visible on the out_* ports after edge N (1 cycle). Throughput is 1 entry/cycle with out_ready held high.
- Ordering is strict FIFO. No entry is dropped or duplicated except by flush.
- Flush:
  - flush=1 forces count to 0 at the next edge.
  - It overrides a push and a pop in the same cycle; the pushed entry is discarded.
  - in_ready is unaffected in the flush cycle.
- Reset (asynchronous, rst_n=0):
  - count=0, so out_valid=0 and in_ready=1.
  - out_imm=0, out_tag=0, out_illegal=0; all slot contents are cleared to 0.
  - Reset mid-transfer discards all entries. The first accept after release happens at the first rising edge with rst_n=1.
- out_* payload holds stable while out_valid=1 and out_ready=0.
- When count=0 the payload holds its last value and must not be relied on. After reset it is 0.

Test Plan:
- XLEN=32, push op=I, din=0x1FFE001 (addi x1,x0,-1) with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0.
- Push op=B, din=0x1FC001D (beq -4) -> out_imm=0xFFFFFFFC. Push op=U, din=0x02468A1 -> out_imm=0x12345000. Push op=Z, din[12:8]=0x1F -> out_imm=0x0000001F.
- XLEN=64: op=U, din=0x1000001 (lui 0x80000) -> out_imm=0xFFFFFFFF80000000. op=Is, din[18:13]=0x3F -> 0x3F. The same Is input with XLEN=32 -> 0x1F.
- out_ready=0, push tags 1,2,3 back-to-back:
  - in_ready drops after the second accept and tag 3 is held off.
  - Then raise out_ready: tags emerge 1,2,3 in order, one per cycle, with in_ready returning the cycle after the first pop.
- op=9, any din -> out_imm=0, out_illegal=1, tag passed through unchanged.
- FULL buffer, then assert flush together with pop and in_valid -> next cycle out_valid=0, in_ready=1, no entry emitted. Assert rst_n=0 asynchronously mid-stream -> out_valid=0 immediately, out_imm=0.
